// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Purpose  : Fetch PC, IF/ID pipeline register and load-use/redirect hazard
//            logic. Optional stall/flush counters under IF_ID_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_o,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ex_mem_rd,
    input  logic [4:0]  ex_rd,
    output logic [31:0] instr_fo,
    output logic [31:0] PC_fo,
    output logic [31:0] PC_plus_4_fo,
    output logic [4:0]  Rs1_fo,
    output logic [4:0]  Rs2_fo,
    output logic [4:0]  Rd_fo,
    output logic [2:0]  I_aluctrl_fn7_fo,
    output logic [2:0]  I_aluctrl_fn3_fo,
    output logic        valid_fo,
    output logic        bubble
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_S     = 7'b0100011;
    localparam logic [6:0] c_OP_B     = 7'b1100011;

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcf_q,   pcf_d;
    logic        valid_q, valid_d;

    logic [6:0]  w_opcode;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_hazard;

    assign w_opcode   = instr_q[6:0];
    assign w_uses_rs1 = !((w_opcode == c_OP_LUI) || (w_opcode == c_OP_AUIPC) ||
                          (w_opcode == c_OP_JAL));
    assign w_uses_rs2 = (w_opcode == c_OP_R) || (w_opcode == c_OP_S) ||
                        (w_opcode == c_OP_B);

    assign w_hazard = valid_q && ex_mem_rd && (ex_rd != 5'd0) &&
                      ((w_uses_rs1 && (ex_rd == instr_q[19:15])) ||
                       (w_uses_rs2 && (ex_rd == instr_q[24:20])));

    assign bubble = redirect || w_hazard || !valid_q;

    // Redirect outranks the stall: the stalled instruction is being killed anyway.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcf_d   = pcf_q;
        valid_d = valid_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!w_hazard) begin
            pc_d    = pc_q + 32'd4;
            instr_d = imem_rdata;
            pcf_d   = pc_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcf_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcf_q   <= pcf_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o             = pc_q;
    assign instr_fo         = instr_q;
    assign PC_fo            = pcf_q;
    assign PC_plus_4_fo     = pcf_q + 32'd4;
    assign valid_fo         = valid_q;
    assign Rs1_fo           = instr_q[19:15];
    assign Rs2_fo           = instr_q[24:20];
    assign Rd_fo            = instr_q[11:7];
    assign I_aluctrl_fn7_fo = {instr_q[31], instr_q[30], instr_q[25]};
    assign I_aluctrl_fn3_fo = instr_q[14:12];

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    assign stall_d = (w_hazard && !redirect) ? stall_q + 32'd1 : stall_q;
    assign flush_d = redirect ? flush_q + 32'd1 : flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif

endmodule
`default_nettype wire
